// File: rtl/card_ram_ctrl.sv
// card_ram_ctrl: timed access controller for the 256Kx8 asynchronous SRAM
// behind the slot-5 RAM card. It serves CPU card-RAM cycles through a
// one-deep pending register, and can also serve a DMA requester through
// a req/ack port.
// Build option: define CARD_RAM_DMA_EN to enable the DMA port. When it is
// not defined, the controller serves the CPU only and dma_ack/dma_dout are 0.
module card_ram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              cpu_strobe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              card_ram_we,
    input  logic              card_ram_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_dout_valid,
    output logic              cpu_overrun,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_din,
    output logic              dma_ack,
    output logic [7:0]        dma_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic              cur_we;
    logic              owner_dma;
    logic              last_access;

    logic              pend_valid;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_data;

    logic              cpu_req;
    logic              start;
    logic              start_cpu;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              we_nxt;

    // A strobe counts only when the decoder enables card RAM for that direction.
    assign cpu_req = cpu_strobe & ((cpu_we & card_ram_we) | (~cpu_we & card_ram_rd));

    assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);
    assign busy        = (state != IDLE) || pend_valid;
    assign we_nxt      = start ? sel_we : cur_we;

`ifndef CARD_RAM_DMA_EN
    // DMA inputs have no function in a CPU-only build.
    logic unused_dma;
    assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_din};
    assign dma_ack    = 1'b0;
    assign dma_dout   = 8'h00;
`endif

    // Next state and owner selection; a pending CPU request wins, then a
    // request arriving this cycle from an idle bus, then DMA.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        start     = 1'b0;
        start_cpu = 1'b0;
        sel_we    = pend_we;
        sel_addr  = pend_addr;
        sel_data  = pend_data;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    start     = 1'b1;
                    start_cpu = 1'b1;
                end else if (cpu_req) begin
                    start     = 1'b1;
                    start_cpu = 1'b1;
                    sel_we    = cpu_we;
                    sel_addr  = ram_addr;
                    sel_data  = cpu_din;
                end
`ifdef CARD_RAM_DMA_EN
                else if (dma_req) begin
                    start    = 1'b1;
                    sel_we   = dma_we;
                    sel_addr = dma_addr;
                    sel_data = dma_din;
                end
`endif
                if (start) state_nxt = SETUP;
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and strobe-width down-counter.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == SETUP)
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == ACCESS && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // One-deep CPU pending register; a second request while one is waiting is dropped.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: the pending payload is reset too; it is only a few flops and keeps sram_addr/dq_o deterministic.
            pend_valid  <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= 8'h00;
            cpu_overrun <= 1'b0;
        end else begin
            if (cpu_req) begin
                if (pend_valid) begin
                    cpu_overrun <= 1'b1;
                end else if (state != IDLE) begin
                    pend_valid <= 1'b1;
                    pend_we    <= cpu_we;
                    pend_addr  <= ram_addr;
                    pend_data  <= cpu_din;
                end
            end
            if (state == IDLE && pend_valid)
                pend_valid <= 1'b0;
        end
    end

    // SRAM pins are registered from the next state so strobes are glitch-free.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sram_addr  <= '0;
            sram_dq_o  <= 8'h00;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            cur_we     <= 1'b0;
            owner_dma  <= 1'b0;
        end else begin
            if (start) begin
                sram_addr <= sel_addr;
                cur_we    <= sel_we;
                owner_dma <= ~start_cpu;
                if (sel_we) sram_dq_o <= sel_data;
            end
            sram_ce_n  <= (state_nxt == IDLE);
            sram_oe_n  <= ~((state_nxt == ACCESS) && !we_nxt);
            sram_we_n  <= ~((state_nxt == ACCESS) && we_nxt);
            sram_dq_oe <= (state_nxt != IDLE) && we_nxt;
        end
    end

    // Read data is captured on the last strobe cycle and presented during HOLD.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            cpu_dout       <= 8'h00;
            cpu_dout_valid <= 1'b0;
        end else begin
            cpu_dout_valid <= last_access && !owner_dma && !cur_we;
            if (last_access && !owner_dma && !cur_we)
                cpu_dout <= sram_dq_i;
        end
    end

`ifdef CARD_RAM_DMA_EN
    // DMA completion: ack on every DMA access, read data only on reads.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            dma_ack  <= 1'b0;
            dma_dout <= 8'h00;
        end else begin
            dma_ack <= last_access && owner_dma;
            if (last_access && owner_dma && !cur_we)
                dma_dout <= sram_dq_i;
        end
    end
`endif

endmodule

// File: tb/tb_card_ram_ctrl.sv
// Testbench for card_ram_ctrl: SRAM behavioural model, directed CPU/DMA
// stimulus, and a scoreboard monitor comparing read data and pulse timing.
module tb_card_ram_ctrl;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              reset_in;
    logic              cpu_strobe = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] ram_addr = '0;
    logic              card_ram_we = 1'b0;
    logic              card_ram_rd = 1'b0;
    logic [7:0]        cpu_din = 8'h00;
    logic [7:0]        cpu_dout;
    logic              cpu_dout_valid;
    logic              cpu_overrun;
    logic              dma_req = 1'b0;
    logic              dma_we = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [7:0]        dma_din = 8'h00;
    logic              dma_ack;
    logic [7:0]        dma_dout;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dq_o;
    logic              sram_dq_oe;
    logic [7:0]        sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    card_ram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_in(reset_in),
        .cpu_strobe(cpu_strobe), .cpu_we(cpu_we), .ram_addr(ram_addr),
        .card_ram_we(card_ram_we), .card_ram_rd(card_ram_rd), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid), .cpu_overrun(cpu_overrun),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_ack(dma_ack), .dma_dout(dma_dout), .busy(busy),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read while ce_n/oe_n low, write on we_n rising.
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hFF;
    always @(posedge sram_we_n) if (!sram_ce_n) mem[sram_addr] = sram_dq_o;

    typedef struct {
        logic [7:0] data;
        int         cyc;   // expected pulse cycle, -1 when not timed
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int oe_low = 0, we_low = 0, dqoe_hi = 0, ce_low = 0, busy_hi = 0, excl_viol = 0, ack_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pin statistics and scoreboard pops on completion pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (sram_dq_oe) dqoe_hi++;
        if (!sram_ce_n) ce_low++;
        if (busy) busy_hi++;
        if (!sram_oe_n && sram_dq_oe) excl_viol++;
        if (dma_ack) ack_cnt++;
        if (cpu_dout_valid) begin
            if (cpu_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cpu_unexpected_valid: pulse with data 0x%0h, none expected (cycle %0d)", cpu_dout, cyc);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_rd_data", 32'(cpu_dout), 32'(e.data));
                if (e.cyc >= 0) check("cpu_rd_cycle", cyc, e.cyc);
            end
        end
        if (dma_ack) begin
            if (dma_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dma_unexpected_ack: ack with data 0x%0h, none expected (cycle %0d)", dma_dout, cyc);
            end else begin
                e = dma_q.pop_front();
                check("dma_rd_data", 32'(dma_dout), 32'(e.data));
                if (e.cyc >= 0) check("dma_ack_cycle", cyc, e.cyc);
            end
        end
    end

    // One CPU bus cycle; s returns the strobe cycle number.
    task automatic cpu_op(input logic we, input logic wr_en, input logic rd_en,
                          input logic [ADDR_W-1:0] addr, input logic [7:0] din, output int s);
        @(posedge clk); #1;
        cpu_strobe = 1'b1; cpu_we = we; card_ram_we = wr_en; card_ram_rd = rd_en;
        ram_addr = addr; cpu_din = din;
        s = cyc;
        @(posedge clk); #1;
        cpu_strobe = 1'b0; card_ram_we = 1'b0; card_ram_rd = 1'b0; cpu_we = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    initial begin
        int s, sa, snap_a, snap_b, snap_c;
        bit done;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[18'h2D123] = 8'hA5;
        mem[18'h00042] = 8'h77;
        mem[18'h3FFFF] = 8'h99;
        mem[18'h00000] = 8'h11;
        mem[18'h01234] = 8'h5A;

        // Reset values
        reset_in = 1'b1;
        #23;
        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_addr_dq", {6'd0, sram_addr, sram_dq_o}, 0);
        check("rst_cpu_out", {22'd0, cpu_dout, cpu_dout_valid, cpu_overrun}, 0);
        check("rst_dma_busy", {22'd0, dma_dout, dma_ack, busy}, 0);
        @(negedge clk); reset_in = 1'b0;
        repeat (2) @(posedge clk);

        // CPU read from an idle bus: valid pulse four cycles after the strobe
        snap_a = oe_low;
        cpu_op(1'b0, 1'b0, 1'b1, 18'h2D123, 8'h00, s);
        cpu_q.push_back(mk(8'hA5, s + 4));
        repeat (6) @(posedge clk);
        check("rd_oe_low_cycles", oe_low - snap_a, 2);

        // CPU write: two we_n cycles, dq_oe over SETUP..HOLD, no valid pulse
        snap_a = we_low; snap_b = dqoe_hi;
        cpu_op(1'b1, 1'b1, 1'b0, 18'h10000, 8'h3C, s);
        repeat (6) @(posedge clk);
        check("wr_we_low_cycles", we_low - snap_a, 2);
        check("wr_dq_oe_cycles", dqoe_hi - snap_b, 4);
        check("wr_mem_content", 32'(mem[18'h10000]), 32'h3C);
        cpu_op(1'b0, 1'b0, 1'b1, 18'h10000, 8'h00, s);
        cpu_q.push_back(mk(8'h3C, s + 4));
        repeat (6) @(posedge clk);

        // ROM/IO cycle: cpu_we set but the decoder does not enable card RAM
        snap_a = busy_hi; snap_c = ce_low;
        cpu_op(1'b1, 1'b0, 1'b1, 18'h00042, 8'hEE, s);
        repeat (6) @(posedge clk);
        check("rom_busy_cycles", busy_hi - snap_a, 0);
        check("rom_ce_low_cycles", ce_low - snap_c, 0);

`ifdef CARD_RAM_DMA_EN
        // DMA and CPU request in the same cycle: CPU first, then DMA
        @(posedge clk); #1;
        cpu_strobe = 1'b1; cpu_we = 1'b0; card_ram_rd = 1'b1; ram_addr = 18'h2D123;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 18'h01234;
        s = cyc;
        @(posedge clk); #1;
        cpu_strobe = 1'b0; card_ram_rd = 1'b0;
        cpu_q.push_back(mk(8'hA5, s + 4));
        dma_q.push_back(mk(8'h5A, s + 9));
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (dma_ack) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL dma_ack_timeout: no ack within 40 cycles");
        end
        @(posedge clk); #1; dma_req = 1'b0;
        repeat (6) @(posedge clk);
        check("dma_ack_count", ack_cnt, 1);
`endif

        // Overrun: second strobe pends during an access, third is dropped
        check("overrun_before", 32'(cpu_overrun), 0);
        cpu_op(1'b0, 1'b0, 1'b1, 18'h00042, 8'h00, sa);
        cpu_q.push_back(mk(8'h77, sa + 4));
        cpu_op(1'b0, 1'b0, 1'b1, 18'h3FFFF, 8'h00, s);
        cpu_q.push_back(mk(8'h99, sa + 9));
        cpu_op(1'b0, 1'b0, 1'b1, 18'h00000, 8'h00, s);
        repeat (10) @(posedge clk);
        check("overrun_set", 32'(cpu_overrun), 1);

        // Asynchronous reset in the middle of a write's ACCESS phase
        cpu_op(1'b1, 1'b1, 1'b0, 18'h00100, 8'hC3, s);
        @(negedge clk);            // SETUP
        @(negedge clk);            // first ACCESS cycle
        check("pre_rst_we_n", 32'(sram_we_n), 0);
        #1 reset_in = 1'b1;
        #1;
        check("async_rst_strobes", {29'd0, sram_we_n, sram_ce_n, sram_dq_oe}, 32'b110);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_in = 1'b0;
        snap_c = ce_low;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", {30'd0, busy, cpu_overrun}, 0);
        check("post_rst_no_access", ce_low - snap_c, 0);

        // Drain the scoreboard
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cpu_q.size() == 0 && dma_q.size() == 0) done = 1'b1;
        end
        check("cpu_queue_drained", cpu_q.size(), 0);
        check("dma_queue_drained", dma_q.size(), 0);
        check("oe_dq_oe_exclusive", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
